// File: rtl/uart_tx_if.sv
// Byte handshake and line-side signals of the UART transmitter.
// master: byte producer; slave: uart_tx.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;
  logic       tx;
  logic       busy;

  modport master (output data_in, output valid_in, input ready, input tx, input busy);
  modport slave  (input data_in, input valid_in, output ready, output tx, output busy);
endinterface

// File: rtl/uart_tx.sv
// Fixed-baud UART transmitter: 8N1, LSB first, valid/ready byte intake.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit (even, or
// odd when PARITY_ODD=1) between data bit 7 and the stop bit.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned BIT_PERIOD = CLK_FREQ / BAUD,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  bus
);

  localparam int unsigned BAUD_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_PERIOD - 1);

  // Reject configurations the bit timing cannot honour.
  if (BIT_PERIOD < 2) begin : g_bad_period
    $error("uart_tx: BIT_PERIOD must be >= 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif
  logic              bit_done_c;

  // Last clock of the current bit period.
  assign bit_done_c = (baud == BAUD_LAST);

  // Frame sequencer with registered line and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          baud <= '0;
          if (bus.valid_in && ready_q) begin
            shreg   <= bus.data_in;
`ifdef UART_TX_PARITY_EN
            par     <= (^bus.data_in) ^ 1'(PARITY_ODD);
`endif
            bit_idx <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_done_c) begin
            baud    <= '0;
            bit_idx <= '0;
            tx_q    <= shreg[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_done_c) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= par;
              state <= S_PARITY;
`else
              tx_q  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              // Next line bit is the one that becomes shreg[0] after the shift.
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done_c) begin
            baud  <= '0;
            tx_q  <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_done_c) begin
            baud    <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          baud    <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BIT_PERIOD=4 (CLK_FREQ=400, BAUD=100).
module tb_uart_tx;

  localparam int unsigned BP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif
  localparam int TO = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if bus_e ();
  uart_tx #(.CLK_FREQ(400), .BAUD(100), .PARITY_ODD(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(bus_e)
  );
`ifdef UART_TX_PARITY_EN
  uart_tx_if bus_o ();
  uart_tx #(.CLK_FREQ(400), .BAUD(100), .PARITY_ODD(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bus(bus_o)
  );
`endif

  int tests = 0;
  int fails = 0;

  // frame: line bits in send order, index 0 = start bit, index 9 = stop bit.
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par_even;
  } vec_t;

  vec_t vecs[5];
  logic [FB-1:0] exp_e;
`ifdef UART_TX_PARITY_EN
  logic [FB-1:0] exp_o;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    bus_e.valid_in = v;
    bus_e.data_in  = d;
`ifdef UART_TX_PARITY_EN
    bus_o.valid_in = v;
    bus_o.data_in  = d;
`endif
  endtask

  task automatic set_exp(input vec_t v);
`ifdef UART_TX_PARITY_EN
    exp_e = {1'b1, v.par_even, v.frame[8:0]};
    exp_o = {1'b1, ~v.par_even, v.frame[8:0]};
`else
    exp_e = v.frame;
`endif
  endtask

  // Called at the negedge right after the accepting edge; samples every cycle of the frame.
  task automatic check_frame(input string name, input int pulse_at);
    logic [BP-1:0] smp_e;
    int            low_e;
`ifdef UART_TX_PARITY_EN
    logic [BP-1:0] smp_o;
    int            low_o;
    low_o = 0;
`endif
    low_e = 0;
    for (int b = 0; b < int'(FB); b++) begin
      for (int c = 0; c < int'(BP); c++) begin
        if (pulse_at >= 0 && b * int'(BP) + c == pulse_at) drive(1'b1, 8'h3C);
        else if (pulse_at >= 0 && b * int'(BP) + c == pulse_at + 1) drive(1'b0, 8'h00);
        smp_e[c] = bus_e.tx;
        if (bus_e.ready === 1'b0 && bus_e.busy === 1'b1) low_e++;
`ifdef UART_TX_PARITY_EN
        smp_o[c] = bus_o.tx;
        if (bus_o.ready === 1'b0 && bus_o.busy === 1'b1) low_o++;
`endif
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d tx", name, b), 32'(smp_e), 32'({BP{exp_e[b]}}));
`ifdef UART_TX_PARITY_EN
      chk($sformatf("%s bit%0d tx_odd", name, b), 32'(smp_o), 32'({BP{exp_o[b]}}));
`endif
    end
    chk({name, " ready-low cycles"}, 32'(low_e), 32'(FB * BP));
    chk({name, " end ready/busy/tx"}, {29'd0, bus_e.ready, bus_e.busy, bus_e.tx}, 32'b101);
`ifdef UART_TX_PARITY_EN
    chk({name, " ready-low cycles odd"}, 32'(low_o), 32'(FB * BP));
`endif
  endtask

  task automatic send(input vec_t v, input string name, input int pulse_at);
    int n;
    n = 0;
    @(negedge clk);
    while (bus_e.ready !== 1'b1 && n < TO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TO) chk({name, " wait ready timeout"}, 32'(n), 32'(0));
    set_exp(v);
    drive(1'b1, v.data);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00);
    check_frame(name, pulse_at);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v00, vff;
    int   bad;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h81, 10'b1100000010, 1'b0};
    vecs[2] = '{8'h7F, 10'b1011111110, 1'b1};
    vecs[3] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[4] = '{8'h3C, 10'b1001111000, 1'b0};
    v00     = '{8'h00, 10'b1000000000, 1'b0};
    vff     = '{8'hFF, 10'b1111111110, 1'b0};

    // Reset held 3 clocks with a byte offered: line stays idle.
    rst_n = 1'b0;
    drive(1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset cyc%0d ready/busy/tx", i), {29'd0, bus_e.ready, bus_e.busy, bus_e.tx}, 32'b101);
    end
    drive(1'b0, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset idle", {29'd0, bus_e.ready, bus_e.busy, bus_e.tx}, 32'b101);

    // Table of single frames.
    foreach (vecs[i]) send(vecs[i], $sformatf("byte %02h", vecs[i].data), -1);

    // Back-to-back with valid_in held: exactly one idle clock between frames.
    @(negedge clk);
    set_exp(v00);
    drive(1'b1, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check_frame("b2b 00", -1);
    set_exp(vff);
    drive(1'b1, 8'hFF);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00);
    check_frame("b2b FF", -1);

    // valid_in pulsed mid-frame with 0x3C: ignored, no extra frame.
    send(vecs[0], "ignored valid", 15);
    bad = 0;
    for (int i = 0; i < int'(2 * BP); i++) begin
      if (bus_e.tx !== 1'b1 || bus_e.ready !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("no extra frame", 32'(bad), 32'd0);

    // Reset during data bit 3 aborts the frame.
    drive(1'b1, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'h00);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid-frame reset ready/busy/tx", {29'd0, bus_e.ready, bus_e.busy, bus_e.tx}, 32'b101);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_e.tx !== 1'b1 || bus_e.ready !== 1'b1) bad++;
    end
    chk("idle after abort", 32'(bad), 32'd0);
    send(vecs[1], "after abort 81", -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
